// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - per-register countdown load-use hazard unit between ID and EX
//
// Stalls ID, bubbles ID/EX and holds the fetch PC until every source register
// read by the ID instruction can be forwarded. Each architectural register has
// a 4-bit countdown that is armed by a load in EX, so memory latency may span
// several cycles.
//
// Optional feature macro: LOAD_USE_PERF_EN (adds stall_cycles / stall_events).
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   valid_ex, flush_ex                EX holds a live instruction / EX squashed
//   mem_read_ex, reg_write_ex, rd_ex  EX is a load / writes rd_ex / destination
//   valid_id, flush_id                ID holds a live instruction / ID squashed
//   rn_id, rm_id, use_rn_id, use_rm_id  ID sources and their use qualifiers
//   pc_id                             PC of the ID instruction
//   stall_id                          zero ID/EX controls and hold IF/ID
//   pc_write, pc_if                   PC reload strobe and value (pc_id on stall)
//   busy                              any scoreboard counter nonzero
//   stall_cycles, stall_events        perf counters (LOAD_USE_PERF_EN only)

`timescale 1ns/1ps

module load_use_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int PC_W         = 32,
  parameter int LOAD_LATENCY = 1,   // legal range 1..15
  parameter int ZERO_REG     = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_ex,
  input  logic                  flush_ex,
  input  logic                  mem_read_ex,
  input  logic                  reg_write_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  valid_id,
  input  logic                  flush_id,
  input  logic [REG_ADDR_W-1:0] rn_id,
  input  logic [REG_ADDR_W-1:0] rm_id,
  input  logic                  use_rn_id,
  input  logic                  use_rm_id,
  input  logic [PC_W-1:0]       pc_id,
  output logic                  stall_id,
  output logic                  pc_write,
  output logic [PC_W-1:0]       pc_if,
  output logic                  busy
`ifdef LOAD_USE_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           stall_events
`endif
);

  localparam int                     NREGS     = 1 << REG_ADDR_W;
  localparam logic [3:0]             LOAD_INIT = 4'(LOAD_LATENCY - 1);
  localparam logic [REG_ADDR_W-1:0]  ZERO_IDX  = REG_ADDR_W'(ZERO_REG);

  logic [3:0] cnt [NREGS];

  logic ld_ex;
  logic wr_ex;
  logic hit_rn;
  logic hit_rm;

  assign ld_ex = valid_ex & ~flush_ex & mem_read_ex & reg_write_ex & (rd_ex != ZERO_IDX);
  assign wr_ex = valid_ex & ~flush_ex & reg_write_ex & ~mem_read_ex & (rd_ex != ZERO_IDX);

  // The direct EX compare covers the first stall cycle; the counter covers
  // the remaining LOAD_LATENCY-1 cycles once the load has left EX.
  assign hit_rn = use_rn_id & (rn_id != ZERO_IDX) &
                  ((ld_ex & (rn_id == rd_ex)) | (cnt[rn_id] != 4'd0));
  assign hit_rm = use_rm_id & (rm_id != ZERO_IDX) &
                  ((ld_ex & (rm_id == rd_ex)) | (cnt[rm_id] != 4'd0));

  // Gated by reset_n so an in-flight load in EX cannot hold the stall while
  // the unit is being reset.
  assign stall_id = reset_n & valid_id & ~flush_id & (hit_rn | hit_rm);
  assign pc_write = stall_id;
  assign pc_if    = stall_id ? pc_id : '0;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      busy = busy | (cnt[i] != 4'd0);
    end
  end

  // A younger ALU write to the same register clears the pending load (WAW):
  // the forwarding network supplies the younger value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (ld_ex && (rd_ex == REG_ADDR_W'(i))) begin
          cnt[i] <= LOAD_INIT;
        end else if (wr_ex && (rd_ex == REG_ADDR_W'(i))) begin
          cnt[i] <= 4'd0;
        end else if (cnt[i] != 4'd0) begin
          cnt[i] <= cnt[i] - 4'd1;
        end
      end
    end
  end

`ifdef LOAD_USE_PERF_EN
  logic stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q      <= 1'b0;
      stall_cycles <= 32'd0;
      stall_events <= 16'd0;
    end else begin
      stall_q      <= stall_id;
      stall_cycles <= stall_cycles + 32'(stall_id);
      stall_events <= stall_events + 16'(stall_id & ~stall_q);
    end
  end
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb/tb_load_use_scoreboard.sv - directed self-checking bench for load_use_scoreboard

`timescale 1ns/1ps

module tb_load_use_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_ex, flush_ex, mem_read_ex, reg_write_ex;
  logic [4:0]  rd_ex;
  logic        valid_id, flush_id, use_rn_id, use_rm_id;
  logic [4:0]  rn_id, rm_id;
  logic [31:0] pc_id;

  logic        s1_stall, s1_pcw, s1_busy;
  logic [31:0] s1_pcif;
  logic        s3_stall, s3_pcw, s3_busy;
  logic [31:0] s3_pcif;
`ifdef LOAD_USE_PERF_EN
  logic [31:0] s1_scyc, s3_scyc, scyc_base;
  logic [15:0] s1_sevt, s3_sevt, sevt_base;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_use_scoreboard #(.REG_ADDR_W(5), .PC_W(32), .LOAD_LATENCY(1), .ZERO_REG(31)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .valid_ex(valid_ex), .flush_ex(flush_ex), .mem_read_ex(mem_read_ex),
    .reg_write_ex(reg_write_ex), .rd_ex(rd_ex),
    .valid_id(valid_id), .flush_id(flush_id), .rn_id(rn_id), .rm_id(rm_id),
    .use_rn_id(use_rn_id), .use_rm_id(use_rm_id), .pc_id(pc_id),
    .stall_id(s1_stall), .pc_write(s1_pcw), .pc_if(s1_pcif), .busy(s1_busy)
`ifdef LOAD_USE_PERF_EN
    , .stall_cycles(s1_scyc), .stall_events(s1_sevt)
`endif
  );

  load_use_scoreboard #(.REG_ADDR_W(5), .PC_W(32), .LOAD_LATENCY(3), .ZERO_REG(31)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .valid_ex(valid_ex), .flush_ex(flush_ex), .mem_read_ex(mem_read_ex),
    .reg_write_ex(reg_write_ex), .rd_ex(rd_ex),
    .valid_id(valid_id), .flush_id(flush_id), .rn_id(rn_id), .rm_id(rm_id),
    .use_rn_id(use_rn_id), .use_rm_id(use_rm_id), .pc_id(pc_id),
    .stall_id(s3_stall), .pc_write(s3_pcw), .pc_if(s3_pcif), .busy(s3_busy)
`ifdef LOAD_USE_PERF_EN
    , .stall_cycles(s3_scyc), .stall_events(s3_sevt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ex_none();
    valid_ex = 1'b0; flush_ex = 1'b0; mem_read_ex = 1'b0; reg_write_ex = 1'b0; rd_ex = 5'd0;
  endtask

  task automatic ex_load(input logic [4:0] rd, input logic fl);
    valid_ex = 1'b1; flush_ex = fl; mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = rd;
  endtask

  task automatic ex_alu(input logic [4:0] rd);
    valid_ex = 1'b1; flush_ex = 1'b0; mem_read_ex = 1'b0; reg_write_ex = 1'b1; rd_ex = rd;
  endtask

  task automatic id_read(input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                         input logic urm, input logic fl, input logic [31:0] pc);
    valid_id = 1'b1; flush_id = fl; rn_id = rn; rm_id = rm;
    use_rn_id = urn; use_rm_id = urm; pc_id = pc;
  endtask

  task automatic id_none();
    valid_id = 1'b0; flush_id = 1'b0; rn_id = 5'd0; rm_id = 5'd0;
    use_rn_id = 1'b0; use_rm_id = 1'b0; pc_id = 32'd0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    ex_none();
    id_none();

    // Reset state
    step(); #1;
    chk("rst_stall1", {31'd0, s1_stall}, 32'd0);
    chk("rst_stall3", {31'd0, s3_stall}, 32'd0);
    chk("rst_pcw3",   {31'd0, s3_pcw},   32'd0);
    chk("rst_pcif3",  s3_pcif,           32'd0);
    chk("rst_busy3",  {31'd0, s3_busy},  32'd0);
    step();
    reset_n = 1'b1;

`ifdef LOAD_USE_PERF_EN
    #1;
    scyc_base = s3_scyc;
    sevt_base = s3_sevt;
`endif

    // Immediate consumer: LL=1 stalls 1 cycle, LL=3 stalls 3 cycles
    step(); ex_load(5'd5, 1'b0); id_read(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 32'h40); #1;
    chk("imm_c0_stall1", {31'd0, s1_stall}, 32'd1);
    chk("imm_c0_pcw1",   {31'd0, s1_pcw},   32'd1);
    chk("imm_c0_pcif1",  s1_pcif,           32'h40);
    chk("imm_c0_busy1",  {31'd0, s1_busy},  32'd0);
    chk("imm_c0_stall3", {31'd0, s3_stall}, 32'd1);
    step(); ex_none(); #1;
    chk("imm_c1_stall1", {31'd0, s1_stall}, 32'd0);
    chk("imm_c1_pcif1",  s1_pcif,           32'd0);
    chk("imm_c1_busy1",  {31'd0, s1_busy},  32'd0);
    chk("imm_c1_stall3", {31'd0, s3_stall}, 32'd1);
    chk("imm_c1_busy3",  {31'd0, s3_busy},  32'd1);
    step(); #1;
    chk("imm_c2_stall3", {31'd0, s3_stall}, 32'd1);
    chk("imm_c2_pcif3",  s3_pcif,           32'h40);
    step(); #1;
    chk("imm_c3_stall3", {31'd0, s3_stall}, 32'd0);
    chk("imm_c3_busy3",  {31'd0, s3_busy},  32'd0);
`ifdef LOAD_USE_PERF_EN
    chk("perf_cycles", s3_scyc - scyc_base, 32'd3);
    chk("perf_events", {16'd0, s3_sevt - sevt_base}, 32'd1);
`endif

    // Consumer two instructions behind: 2 stall cycles on LL=3
    step(); ex_load(5'd5, 1'b0); id_read(5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 32'h44); #1;
    chk("k2_c0_stall3", {31'd0, s3_stall}, 32'd0);
    step(); ex_none(); id_read(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 32'h48); #1;
    chk("k2_c1_stall3", {31'd0, s3_stall}, 32'd1);
    chk("k2_c1_stall1", {31'd0, s1_stall}, 32'd0);
    step(); #1;
    chk("k2_c2_stall3", {31'd0, s3_stall}, 32'd1);
    step(); #1;
    chk("k2_c3_stall3", {31'd0, s3_stall}, 32'd0);

    // Consumer four instructions behind: no stall
    step(); ex_load(5'd5, 1'b0); id_none(); #1;
    step(); ex_none(); id_read(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'h50); #1;
    chk("k4_c1_busy3", {31'd0, s3_busy}, 32'd1);
    step(); #1;
    step(); id_read(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 32'h5c); #1;
    chk("k4_c3_stall3", {31'd0, s3_stall}, 32'd0);
    chk("k4_c3_busy3",  {31'd0, s3_busy},  32'd0);

    // Load to XZR never hazards
    step(); ex_load(5'd31, 1'b0); id_read(5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 32'h60); #1;
    chk("xzr_stall1", {31'd0, s1_stall}, 32'd0);
    chk("xzr_stall3", {31'd0, s3_stall}, 32'd0);
    step(); ex_none(); #1;
    chk("xzr_busy3", {31'd0, s3_busy}, 32'd0);

    // rm matches but is not used
    step(); ex_load(5'd5, 1'b0); id_read(5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h64); #1;
    chk("nouse_c0_stall1", {31'd0, s1_stall}, 32'd0);
    chk("nouse_c0_stall3", {31'd0, s3_stall}, 32'd0);
    step(); ex_none(); #1;
    chk("nouse_c1_stall3", {31'd0, s3_stall}, 32'd0);
    step(); id_none(); #1;
    step(); #1;
    chk("nouse_drain_busy3", {31'd0, s3_busy}, 32'd0);

    // WAW: younger ALU write clears the pending load counter
    step(); ex_load(5'd7, 1'b0); id_none(); #1;
    step(); ex_alu(5'd7); #1;
    chk("waw_c1_busy3", {31'd0, s3_busy}, 32'd1);
    step(); ex_none(); id_read(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 32'h70); #1;
    chk("waw_c2_stall3", {31'd0, s3_stall}, 32'd0);
    chk("waw_c2_busy3",  {31'd0, s3_busy},  32'd0);

    // Two sources on different pending loads: stall until the longer drains
    step(); ex_load(5'd5, 1'b0); id_none(); #1;
    step(); ex_load(5'd6, 1'b0); #1;
    step(); ex_none(); id_read(5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 32'h80); #1;
    chk("two_c2_stall3", {31'd0, s3_stall}, 32'd1);
    step(); #1;
    chk("two_c3_stall3", {31'd0, s3_stall}, 32'd1);
    step(); #1;
    chk("two_c4_stall3", {31'd0, s3_stall}, 32'd0);

    // Reset during a stall with cnt[5]=2
    step(); ex_load(5'd5, 1'b0); id_read(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 32'h90); #1;
    step(); ex_none(); #1;
    chk("rmid_pre_stall3", {31'd0, s3_stall}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rmid_stall3", {31'd0, s3_stall}, 32'd0);
    chk("rmid_pcw3",   {31'd0, s3_pcw},   32'd0);
    chk("rmid_pcif3",  s3_pcif,           32'd0);
    chk("rmid_busy3",  {31'd0, s3_busy},  32'd0);
    step(); reset_n = 1'b1; #1;
    chk("rmid_post_stall3", {31'd0, s3_stall}, 32'd0);

    // flush_ex blocks recording of a load
    step(); ex_load(5'd9, 1'b1); id_read(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 32'ha0); #1;
    chk("fex_c0_stall3", {31'd0, s3_stall}, 32'd0);
    chk("fex_c0_stall1", {31'd0, s1_stall}, 32'd0);
    step(); ex_none(); #1;
    chk("fex_c1_stall3", {31'd0, s3_stall}, 32'd0);
    chk("fex_c1_busy3",  {31'd0, s3_busy},  32'd0);

    // flush_id masks the stall but leaves the counter alone
    step(); ex_load(5'd5, 1'b0); id_read(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 32'hb0); #1;
    chk("fid_c0_stall3", {31'd0, s3_stall}, 32'd0);
    chk("fid_c0_pcif3",  s3_pcif,           32'd0);
    step(); ex_none(); id_read(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 32'hb4); #1;
    chk("fid_c1_stall3", {31'd0, s3_stall}, 32'd1);
    chk("fid_c1_pcif3",  s3_pcif,           32'hb4);
    step(); #1;
    chk("fid_c2_stall3", {31'd0, s3_stall}, 32'd1);
    step(); #1;
    chk("fid_c3_stall3", {31'd0, s3_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Parametrised load-use hazard unit between the ID and EX stages of the pipelined ARM core.
- Replaces the single-cycle combinational check with a per-register countdown scoreboard, so memory latency can exceed one cycle.
- Stalls the ID stage, injects a bubble into ID/EX, and holds the fetch PC until every source register read by the ID instruction is forwardable.
- Tracks operand-use qualifiers, the zero register, flushes and WAW overrides.

Parameters:
- REG_ADDR_W, 5: register index width; the scoreboard has 2^REG_ADDR_W entries.
- PC_W, 32: PC width.
- LOAD_LATENCY, 1: total stall cycles for a consumer immediately behind a load; legal range is 1..15.
- ZERO_REG, 31: index that never creates a hazard (XZR).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- valid_ex  in  1  EX holds a real instruction
- flush_ex  in  1  EX instruction squashed this cycle
- mem_read_ex  in  1  EX instruction is a load
- reg_write_ex  in  1  EX instruction writes rd_ex
- rd_ex  in  REG_ADDR_W  EX destination register
- valid_id  in  1  ID holds a real instruction
- flush_id  in  1  ID instruction squashed this cycle
- rn_id  in  REG_ADDR_W  ID source 1
- rm_id  in  REG_ADDR_W  ID source 2
- use_rn_id  in  1  ID actually reads rn_id
- use_rm_id  in  1  ID actually reads rm_id
- pc_id  in  PC_W  PC of the ID instruction
- stall_id  out  1  1 = zero ID/EX control lines and hold IF/ID
- pc_write  out  1  1 = PC register loads pc_if
- pc_if  out  PC_W  pc_id while stalling, otherwise 0
- busy  out  1  any scoreboard counter nonzero

Behaviour:
- Signal definitions:
  - ld_ex = valid_ex & ~flush_ex & mem_read_ex & reg_write_ex & (rd_ex != ZERO_REG)
  - wr_ex = valid_ex & ~flush_ex & reg_write_ex & ~mem_read_ex & (rd_ex != ZERO_REG)
  - src_hit(r, use) = use & (r != ZERO_REG) & ((ld_ex & r == rd_ex) | cnt[r] != 0)
- stall_id = valid_id & ~flush_id & (src_hit(rn_id, use_rn_id) | src_hit(rm_id, use_rm_id)). This is combinational, with zero-cycle latency.
- pc_write = stall_id; pc_if = stall_id ? pc_id : 0; busy = OR of all cnt.
- Scoreboard: cnt[i] has width 4. All counters update on the rising clk edge, in priority order:
  1. reset_n low: every cnt = 0 asynchronously. stall_id, pc_write and busy go to 0 immediately; pc_if goes to 0. Reset mid-stall drops the stall the same cycle.
  2. ld_ex: cnt[rd_ex] <= LOAD_LATENCY-1. This overwrites any pending value for the same register.
  3. wr_ex: cnt[rd_ex] <= 0. A younger ALU write supersedes the pending load (WAW); forwarding supplies the younger value.
  4. Every other nonzero cnt decrements by 1 and saturates at 0.
- Stall length rules:
  - Consumer directly behind a load stalls exactly LOAD_LATENCY cycles: 1 cycle on the direct EX compare, then LOAD_LATENCY-1 cycles on the counter.
  - Consumer k instructions behind (k ≥ 2) stalls max(0, LOAD_LATENCY-k+1) cycles.
  - With LOAD_LATENCY=1 no counter is ever set; behaviour equals the classic single-cycle check.
- While stall_id=1 the pipeline feeds a bubble into EX (valid_ex=0 next cycle); counters keep decrementing. No deadlock is possible.
- Both sources hit different registers: the stall lasts until both counters reach 0, i.e. the longer of the two.
- Neither flush_id nor flush_ex alters existing counters. flush_ex only blocks recording.

Optional Feature:
- Macro LOAD_USE_PERF_EN.
- Defined:
  - Adds outputs stall_cycles (32) and stall_events (16).
  - stall_cycles increments on every clk where stall_id=1.
  - stall_events increments on each rising transition of stall_id.
  - Both counters wrap on overflow and reset to 0 on reset_n low.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- LOAD_LATENCY=1: LDUR X5 in EX, ID ADD reads X5 (use_rn_id=1) -> stall_id=1, pc_write=1, pc_if=pc_id=0x40 for exactly 1 cycle; busy stays 0.
- LOAD_LATENCY=3: LDUR X5, then immediate consumer of X5 -> stall_id high 3 consecutive cycles. A consumer two instructions later -> 2 stall cycles. A consumer four instructions later -> 0 stall cycles.
- Load to X31, or consumer with use_rm_id=0 on a matching rm_id=5 -> stall_id never asserts.
- LOAD_LATENCY=3: LDUR X7, next cycle ADD X7 (wr_ex) -> cnt[7] cleared. A later reader of X7 sees no stall.
- Stall in progress with cnt[5]=2: assert reset_n=0 -> stall_id, pc_write and busy drop to 0 the same cycle. After release, a reader of X5 does not stall.
- flush_ex=1 on a load to X9 -> no stall for an X9 reader. flush_id=1 during a hazard -> stall_id=0 that cycle. With LOAD_USE_PERF_EN, a 3-cycle stall gives stall_cycles+=3 and stall_events+=1.
